// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Default geometry, address/data typedefs and the hardwired zero register.
package regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_NUM_READ   = 3;
    localparam int unsigned DEF_NUM_WRITE  = 2;

    localparam int unsigned ZERO_REG = 0;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle between issue/writeback (master) and the register file (slave).
interface regfile_mp_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 3,
    parameter int unsigned NUM_WRITE  = 2
);

    logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  rd_addr;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data;
    logic [NUM_READ-1:0]                  rd_busy;
    logic [NUM_WRITE-1:0]                 wr_en;
    logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data;
    logic                                 rsv_en;
    logic [ADDR_WIDTH-1:0]                rsv_addr;
    logic [ADDR_WIDTH-1:0]                busy_count;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_count
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_count
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with reserve-over-release priority and an
// incrementally maintained population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_WRITE  = DEF_NUM_WRITE
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_WRITE-1:0]                 wr_en,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] wr_addr,
    input  logic                                 rsv_en,
    input  logic [ADDR_WIDTH-1:0]                rsv_addr,
    output logic [2**ADDR_WIDTH-1:0]             busy,
    output logic [ADDR_WIDTH-1:0]                busy_count
);

    localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;
    localparam int unsigned CW       = ADDR_WIDTH + 1;

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [NUM_REGS-1:0]   set_vec, clr_vec;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [CW-1:0]         n_rise, n_fall;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int p = 0; p < int'(NUM_WRITE); p++) begin
            if (wr_en[p]) begin
                clr_vec[wr_addr[p]] = 1'b1;
            end
        end
        if (rsv_en) begin
            set_vec[rsv_addr] = 1'b1;
        end
        set_vec[ZERO_REG] = 1'b0;
        clr_vec[ZERO_REG] = 1'b0;

        // A reserve on the same edge as a release keeps the bit set.
        busy_d = set_vec | (busy_q & ~clr_vec);

        n_rise = '0;
        n_fall = '0;
        for (int a = 0; a < int'(NUM_REGS); a++) begin
            n_rise = n_rise + CW'(busy_d[a] & ~busy_q[a]);
            n_fall = n_fall + CW'(busy_q[a] & ~busy_d[a]);
        end
        count_d = ADDR_WIDTH'({1'b0, count_q} + n_rise - n_fall);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and an
// integrated busy scoreboard; r0 reads as zero and is never busy.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = DEF_NUM_READ,
    parameter int unsigned NUM_WRITE  = DEF_NUM_WRITE,
    parameter int unsigned BYPASS     = 1
) (
    input logic         clock,
    input logic         reset_n,
    regfile_mp_if.slave bus
);

    localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_READ-1:0]   byp_hit;
    logic [NUM_READ-1:0]   rsv_hit;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WRITE  (NUM_WRITE)
    ) u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .rsv_en     (bus.rsv_en),
        .rsv_addr   (bus.rsv_addr),
        .busy       (busy),
        .busy_count (bus.busy_count)
    );

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < int'(NUM_WRITE); p++) begin
            if (bus.wr_en[p] && bus.wr_addr[p] != ZERO_ADDR) begin
                regs_d[bus.wr_addr[p]] = bus.wr_data[p];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < int'(NUM_REGS); a++) begin
                regs_q[a] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        byp_hit     = '0;
        rsv_hit     = '0;
        for (int i = 0; i < int'(NUM_READ); i++) begin
            if (bus.rd_addr[i] != ZERO_ADDR) begin
                bus.rd_data[i] = regs_q[bus.rd_addr[i]];
                bus.rd_busy[i] = busy[bus.rd_addr[i]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < int'(NUM_WRITE); p++) begin
                        if (bus.wr_en[p] && bus.wr_addr[p] == bus.rd_addr[i]) begin
                            bus.rd_data[i] = bus.wr_data[p];
                            byp_hit[i]     = 1'b1;
                        end
                    end
                    rsv_hit[i] = bus.rsv_en && (bus.rsv_addr == bus.rd_addr[i]);
                    // A releasing write hides the busy bit unless a new producer
                    // is reserving the same register this cycle.
                    if (byp_hit[i] && !rsv_hit[i]) begin
                        bus.rd_busy[i] = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing and a non-bypassing register file share stimulus.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    regfile_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_READ(3), .NUM_WRITE(2)) bus1 ();
    regfile_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_READ(3), .NUM_WRITE(2)) bus0 ();

    assign bus0.rd_addr  = bus1.rd_addr;
    assign bus0.wr_en    = bus1.wr_en;
    assign bus0.wr_addr  = bus1.wr_addr;
    assign bus0.wr_data  = bus1.wr_data;
    assign bus0.rsv_en   = bus1.rsv_en;
    assign bus0.rsv_addr = bus1.rsv_addr;

    regfile_mp #(.BYPASS(1)) dut_byp (.clock(clock), .reset_n(reset_n), .bus(bus1));
    regfile_mp #(.BYPASS(0)) dut_nob (.clock(clock), .reset_n(reset_n), .bus(bus0));

    task automatic idle();
        bus1.wr_en    = '0;
        bus1.wr_addr  = '0;
        bus1.wr_data  = '0;
        bus1.rsv_en   = 1'b0;
        bus1.rsv_addr = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reg_data_t zero_d;
        zero_d = '0;
        for (int a = 0; a < 32; a++) begin
            for (int i = 0; i < 3; i++) bus1.rd_addr[i] = 5'(a);
            #1;
            for (int i = 0; i < 3; i++) begin
                vectors += 4;
                if (bus1.rd_data[i] !== zero_d) begin
                    miscompares++;
                    $display("FAIL reset_data_byp r%0d p%0d: got %h want 0000", a, i, bus1.rd_data[i]);
                end
                if (bus0.rd_data[i] !== zero_d) begin
                    miscompares++;
                    $display("FAIL reset_data_nob r%0d p%0d: got %h want 0000", a, i, bus0.rd_data[i]);
                end
                if (bus1.rd_busy[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_busy_byp r%0d p%0d: got %b want 0", a, i, bus1.rd_busy[i]);
                end
                if (bus0.rd_busy[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_busy_nob r%0d p%0d: got %b want 0", a, i, bus0.rd_busy[i]);
                end
            end
        end
        vectors += 2;
        if (bus1.busy_count !== 5'd0 || bus0.busy_count !== 5'd0) begin
            miscompares += 2;
            $display("FAIL reset_count: got %0d/%0d want 0", bus1.busy_count, bus0.busy_count);
        end
    endtask

    task automatic test_multi_write();
        bus1.rd_addr    = '0;
        bus1.rd_addr[0] = 5'd5;
        bus1.wr_en      = 2'b11;
        bus1.wr_addr[0] = 5'd5;
        bus1.wr_addr[1] = 5'd5;
        bus1.wr_data[0] = 16'hBEEF;
        bus1.wr_data[1] = 16'h1234;
        #1;
        vectors += 2;
        if (bus1.rd_data[0] !== 16'h1234) begin
            miscompares++;
            $display("FAIL same_cycle_byp: got %h want 1234", bus1.rd_data[0]);
        end
        if (bus0.rd_data[0] !== 16'h0000) begin
            miscompares++;
            $display("FAIL same_cycle_nob: got %h want 0000", bus0.rd_data[0]);
        end
        tick();
        idle();
        #1;
        vectors += 2;
        if (bus1.rd_data[0] !== 16'h1234) begin
            miscompares++;
            $display("FAIL next_cycle_byp: got %h want 1234", bus1.rd_data[0]);
        end
        if (bus0.rd_data[0] !== 16'h1234) begin
            miscompares++;
            $display("FAIL next_cycle_nob: got %h want 1234", bus0.rd_data[0]);
        end
    endtask

    task automatic test_r0();
        bus1.rd_addr    = '0;
        bus1.wr_en      = 2'b01;
        bus1.wr_addr[0] = 5'd0;
        bus1.wr_data[0] = 16'hFFFF;
        bus1.rsv_en     = 1'b1;
        bus1.rsv_addr   = 5'd0;
        #1;
        vectors += 2;
        if (bus1.rd_data[0] !== 16'h0000 || bus1.rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_same_cycle: got %h/%b want 0000/0", bus1.rd_data[0], bus1.rd_busy[0]);
        end
        if (bus0.rd_data[0] !== 16'h0000 || bus0.rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_same_cycle_nob: got %h/%b want 0000/0", bus0.rd_data[0], bus0.rd_busy[0]);
        end
        tick();
        idle();
        #1;
        vectors += 3;
        if (bus1.rd_data[0] !== 16'h0000) begin
            miscompares++;
            $display("FAIL r0_after: got %h want 0000", bus1.rd_data[0]);
        end
        if (bus1.rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_busy_after: got %b want 0", bus1.rd_busy[0]);
        end
        if (bus1.busy_count !== 5'd0) begin
            miscompares++;
            $display("FAIL r0_count: got %0d want 0", bus1.busy_count);
        end
    endtask

    task automatic test_reserve_release();
        bus1.rd_addr[1] = 5'd7;
        bus1.rsv_en     = 1'b1;
        bus1.rsv_addr   = 5'd7;
        tick();
        idle();
        #1;
        vectors += 2;
        if (bus1.rd_busy[1] !== 1'b1 || bus0.rd_busy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL r7_reserved: got %b/%b want 1/1", bus1.rd_busy[1], bus0.rd_busy[1]);
        end
        if (bus1.busy_count !== 5'd1) begin
            miscompares++;
            $display("FAIL r7_count: got %0d want 1", bus1.busy_count);
        end
        bus1.wr_en      = 2'b10;
        bus1.wr_addr[1] = 5'd7;
        bus1.wr_data[1] = 16'h00A5;
        #1;
        vectors += 3;
        if (bus1.rd_busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL r7_mask_byp: got %b want 0", bus1.rd_busy[1]);
        end
        if (bus0.rd_busy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL r7_mask_nob: got %b want 1", bus0.rd_busy[1]);
        end
        if (bus1.rd_data[1] !== 16'h00A5) begin
            miscompares++;
            $display("FAIL r7_fwd: got %h want 00a5", bus1.rd_data[1]);
        end
        tick();
        idle();
        #1;
        vectors += 3;
        if (bus0.rd_data[1] !== 16'h00A5) begin
            miscompares++;
            $display("FAIL r7_data: got %h want 00a5", bus0.rd_data[1]);
        end
        if (bus1.rd_busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL r7_released: got %b want 0", bus1.rd_busy[1]);
        end
        if (bus1.busy_count !== 5'd0) begin
            miscompares++;
            $display("FAIL r7_count_after: got %0d want 0", bus1.busy_count);
        end
    endtask

    task automatic test_rsv_write_same();
        bus1.rd_addr[2] = 5'd9;
        bus1.rsv_en     = 1'b1;
        bus1.rsv_addr   = 5'd9;
        bus1.wr_en      = 2'b01;
        bus1.wr_addr[0] = 5'd9;
        bus1.wr_data[0] = 16'h0042;
        tick();
        idle();
        #1;
        vectors += 3;
        if (bus1.rd_busy[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL r9_busy: got %b want 1", bus1.rd_busy[2]);
        end
        if (bus1.busy_count !== 5'd1) begin
            miscompares++;
            $display("FAIL r9_count: got %0d want 1", bus1.busy_count);
        end
        if (bus1.rd_data[2] !== 16'h0042) begin
            miscompares++;
            $display("FAIL r9_data: got %h want 0042", bus1.rd_data[2]);
        end
        // Write releasing r9 while r9 is re-reserved: busy must stay visible.
        bus1.rsv_en     = 1'b1;
        bus1.rsv_addr   = 5'd9;
        bus1.wr_en      = 2'b10;
        bus1.wr_addr[1] = 5'd9;
        bus1.wr_data[1] = 16'h0043;
        #1;
        vectors++;
        if (bus1.rd_busy[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL r9_rsv_unmask: got %b want 1", bus1.rd_busy[2]);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            bus1.rsv_en   = 1'b1;
            bus1.rsv_addr = (k == 0) ? 5'd3 : (k == 1) ? 5'd4 : 5'd6;
            tick();
        end
        idle();
        bus1.rd_addr[0] = 5'd5;
        bus1.rd_addr[1] = 5'd9;
        bus1.rd_addr[2] = 5'd3;
        #1;
        vectors += 2;
        if (bus1.busy_count !== 5'd4) begin
            miscompares++;
            $display("FAIL pre_reset_count: got %0d want 4", bus1.busy_count);
        end
        if (bus1.rd_data[0] !== 16'h1234 || bus1.rd_busy[2:1] !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_reset_state: got %h/%b want 1234/11",
                     bus1.rd_data[0], bus1.rd_busy[2:1]);
        end
        reset_n = 1'b0;
        #1;
        vectors += 3;
        if (bus1.rd_data !== '0 || bus0.rd_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset_data: got %h/%h want 0", bus1.rd_data, bus0.rd_data);
        end
        if (bus1.rd_busy !== 3'b000 || bus0.rd_busy !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset_busy: got %b/%b want 000", bus1.rd_busy, bus0.rd_busy);
        end
        if (bus1.busy_count !== 5'd0 || bus0.busy_count !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset_count: got %0d/%0d want 0", bus1.busy_count, bus0.busy_count);
        end
        bus1.wr_en      = 2'b01;
        bus1.wr_addr[0] = 5'd5;
        bus1.wr_data[0] = 16'hFFFF;
        bus1.rsv_en     = 1'b1;
        bus1.rsv_addr   = 5'd3;
        tick();
        idle();
        #1;
        vectors += 2;
        if (bus0.rd_data[0] !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_hold_write: got %h want 0000", bus0.rd_data[0]);
        end
        if (bus1.busy_count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_hold_rsv: got %0d want 0", bus1.busy_count);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bus1.wr_en      = 2'b11;
        bus1.wr_addr[0] = 5'd10;
        bus1.wr_data[0] = 16'h1111;
        bus1.wr_addr[1] = 5'd11;
        bus1.wr_data[1] = 16'h2222;
        tick();
        bus1.wr_en      = 2'b10;
        bus1.wr_addr[1] = 5'd10;
        bus1.wr_data[1] = 16'h3333;
        bus1.rd_addr[0] = 5'd10;
        bus1.rd_addr[1] = 5'd11;
        #1;
        vectors += 3;
        if (bus1.rd_data[0] !== 16'h3333) begin
            miscompares++;
            $display("FAIL b2b_byp: got %h want 3333", bus1.rd_data[0]);
        end
        if (bus0.rd_data[0] !== 16'h1111) begin
            miscompares++;
            $display("FAIL b2b_nob: got %h want 1111", bus0.rd_data[0]);
        end
        if (bus0.rd_data[1] !== 16'h2222) begin
            miscompares++;
            $display("FAIL b2b_r11: got %h want 2222", bus0.rd_data[1]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (bus0.rd_data[0] !== 16'h3333) begin
            miscompares++;
            $display("FAIL b2b_final: got %h want 3333", bus0.rd_data[0]);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus1.rd_addr = '0;
        idle();
        #12;
        reset_n = 1'b1;
        tick();
        test_reset();
        test_multi_write();
        test_r0();
        test_reserve_release();
        test_rsv_write_same();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
